// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detection: picks the youngest forwarding stage per source,
// stalls on too-young loads and on a busy multicycle unit, and counts stall cycles.
module hazard_stall_unit #(
    parameter int POST_DEC_LD  = 3,
    parameter int LOAD_LATENCY = 2,
    parameter int NUM_SRC      = 3,
    parameter int REG_W        = 5,
    parameter int MC_LATENCY   = 8,
    parameter int CNT_W        = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dec_valid,
    input  logic [NUM_SRC*REG_W-1:0]       dec_src,
    input  logic [NUM_SRC-1:0]             dec_src_use,
    input  logic [REG_W-1:0]               dec_dst,
    input  logic                           dec_is_mc,
    input  logic [POST_DEC_LD-1:0]         pos_valid,
    input  logic [POST_DEC_LD-1:0]         pos_wr,
    input  logic [POST_DEC_LD-1:0]         pos_load,
    input  logic [POST_DEC_LD*REG_W-1:0]   pos_dst,
    input  logic                           flush,
    output logic [NUM_SRC*POST_DEC_LD-1:0] fwd_sel,
    output logic                           stall_pc,
    output logic [1:0]                     stall_cause,
    output logic                           stall_phase,
    output logic                           mc_busy,
    output logic [CNT_W-1:0]               stall_cycles
);

    localparam int MC_W = 8;

    logic [MC_W-1:0]  mcCnt_q, mcCnt_d;
    logic [REG_W-1:0] mcDst_q, mcDst_d;
    logic             stallPhase_q;
    logic [CNT_W-1:0] stallCycles_q;

    logic loadHaz;
    logic mcDataHaz;
    logic mcHaz;
    logic mcHandoff;
    logic mcIssue;

    // Per source: first (youngest) matching stage wins the forward select; a load there
    // stalls only if its data is not yet forwardable from that stage.
    always_comb begin : matchComb
        logic             hit;
        logic [REG_W-1:0] srcReg;
        fwd_sel   = '0;
        loadHaz   = 1'b0;
        mcDataHaz = 1'b0;
        hit       = 1'b0;
        srcReg    = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            srcReg = dec_src[j*REG_W +: REG_W];
            hit    = 1'b0;
            for (int i = 0; i < POST_DEC_LD; i++) begin
                if (!hit && dec_valid && dec_src_use[j] && pos_valid[i] && pos_wr[i] &&
                    (pos_dst[i*REG_W +: REG_W] == srcReg) && (srcReg != '0)) begin
                    hit                       = 1'b1;
                    fwd_sel[j*POST_DEC_LD + i] = 1'b1;
                    if (pos_load[i] && ((i + 1) < LOAD_LATENCY)) begin
                        loadHaz = 1'b1;
                    end
                end
            end
            if (dec_src_use[j] && (srcReg != '0) && (srcReg == mcDst_q)) begin
                mcDataHaz = 1'b1;
            end
        end
    end

    // A new mc op may enter on the final busy cycle so the unit stays occupied without a
    // gap; readers of the mc result still wait until the unit is fully idle.
    always_comb begin
        mc_busy   = (mcCnt_q != '0);
        mcHandoff = (mcCnt_q == MC_W'(1));
        mcHaz     = dec_valid && mc_busy && ((dec_is_mc && !mcHandoff) || mcDataHaz);
        stall_pc  = (loadHaz || mcHaz) && !flush;
        stall_cause = {mcHaz && !flush, loadHaz && !flush};
        mcIssue   = dec_valid && dec_is_mc && !stall_pc && !flush;
    end

    always_comb begin
        mcCnt_d = mcCnt_q;
        mcDst_d = mcDst_q;
        if (mcIssue) begin
            mcCnt_d = MC_W'(MC_LATENCY);
            mcDst_d = dec_dst;
        end else if (mc_busy) begin
            mcCnt_d = mcCnt_q - MC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcCnt_q       <= '0;
            mcDst_q       <= '0;
            stallPhase_q  <= 1'b0;
            stallCycles_q <= '0;
        end else begin
            mcCnt_q      <= mcCnt_d;
            mcDst_q      <= mcDst_d;
            stallPhase_q <= stall_pc;
            if (stall_pc) begin
                stallCycles_q <= stallCycles_q + CNT_W'(1);
            end
        end
    end

    assign stall_phase  = stallPhase_q;
    assign stall_cycles = stallCycles_q;

endmodule
